// File: rtl/taus_urng_ctrl_if.sv
// Bundle between the URNG controller, its requesters and the Tausworthe URNG.
// The controller connects through the slave modport. The requester/URNG side
// connects through the master modport.
//   start/stop          run control
//   cfg_wr/sel/data     seed write, answered by cfg_err
//   busy/ready          status
//   req/gnt/rnd_data    shared random-word stream
//   en_taus/s*_init     URNG control
//   taus_out            URNG output word
interface taus_urng_ctrl_if #(
    parameter int NREQ = 4
);
    logic            start;
    logic            stop;
    logic            cfg_wr;
    logic [1:0]      cfg_sel;
    logic [63:0]     cfg_data;
    logic            cfg_err;
    logic            busy;
    logic            ready;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [63:0]     rnd_data;
    logic            en_taus;
    logic [63:0]     s1_init;
    logic [63:0]     s2_init;
    logic [63:0]     s3_init;
    logic [63:0]     taus_out;

    modport slave (
        input  start, stop, cfg_wr, cfg_sel, cfg_data, req, taus_out,
        output cfg_err, busy, ready, gnt, rnd_data, en_taus,
               s1_init, s2_init, s3_init
    );

    modport master (
        output start, stop, cfg_wr, cfg_sel, cfg_data, req, taus_out,
        input  cfg_err, busy, ready, gnt, rnd_data, en_taus,
               s1_init, s2_init, s3_init
    );
endinterface

// File: rtl/taus_urng_ctrl.sv
// Sequencing and sharing controller for a 64-bit Tausworthe URNG.
// It owns the three seeds and the URNG enable. After every (re)seed it throws
// away WARMUP enabled cycles of output. It then shares the one-word-per-cycle
// stream among NREQ requesters with round-robin arbitration.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  taus_urng_ctrl_if.slave carrying the control, config, request/grant
//        and URNG signals
// Optional feature macro: TAUS_SEED_CHECK_EN. When it is defined, seed writes
// below the Tausworthe minimums (s1<2, s2<8, s3<16) are rejected and cfg_err
// pulses. When it is undefined, every write is accepted and cfg_err is 0.
module taus_urng_ctrl #(
    parameter int          NREQ   = 4,
    parameter int          WARMUP = 16,
    parameter logic [63:0] S1_DEF = 64'd11357407135578037661,
    parameter logic [63:0] S2_DEF = 64'd16405737874297512876,
    parameter logic [63:0] S3_DEF = 64'd13098074952039773637
) (
    input  logic            clk,
    input  logic            rst,
    taus_urng_ctrl_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(WARMUP);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_RESEED} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q;
    logic [63:0]     rnd_q;
    logic [63:0]     s1_q, s2_q, s3_q;

    logic            seed_ok;
    logic            wr_valid;
    logic            wr_acc;
    logic            pick_vld;
    logic [PW-1:0]   pick_idx;
    logic            grant;

    // cfg_sel==3 is not a seed, so it is neither accepted nor rejected.
    assign wr_valid = bus.cfg_wr && (bus.cfg_sel != 2'd3);
    assign wr_acc   = wr_valid && seed_ok;

`ifdef TAUS_SEED_CHECK_EN
    logic cfg_err_q;

    always_comb begin
        case (bus.cfg_sel)
            2'd0:    seed_ok = (bus.cfg_data >= 64'd2);
            2'd1:    seed_ok = (bus.cfg_data >= 64'd8);
            default: seed_ok = (bus.cfg_data >= 64'd16);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cfg_err_q <= 1'b0;
        else      cfg_err_q <= wr_valid && !seed_ok;
    end

    assign bus.cfg_err = cfg_err_q;
`else
    assign seed_ok     = 1'b1;
    assign bus.cfg_err = 1'b0;
`endif

    // Round-robin pick: walk the requesters circularly, starting at ptr_q.
    always_comb begin
        logic [PW:0] idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
            if (!pick_vld && bus.req[idx[PW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = idx[PW-1:0];
            end
        end
    end

    // A cycle that is leaving RUN (stop or reseed) grants nothing. Its word is
    // dropped along with the rest of the old stream.
    assign grant = (state_q == S_RUN) && !bus.stop && !wr_acc && pick_vld;
    assign ptr_d = (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + PW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_WARMUP;
                    cnt_d   = '0;
                end
            end
            S_WARMUP: begin
                if (cnt_q == CW'(WARMUP-1)) state_d = S_RUN;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            S_RUN: ;
            S_RESEED: begin
                state_d = S_WARMUP;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // An accepted write in IDLE only updates the seed register.
        if (wr_acc && (state_q == S_WARMUP || state_q == S_RUN)) begin
            state_d = S_RESEED;
            cnt_d   = '0;
        end
        if (bus.stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            rnd_q   <= '0;
            s1_q    <= S1_DEF;
            s2_q    <= S2_DEF;
            s3_q    <= S3_DEF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                gnt_q <= NREQ'(1) << pick_idx;
                rnd_q <= bus.taus_out;
                ptr_q <= ptr_d;
            end else begin
                gnt_q <= '0;
            end
            if (wr_acc) begin
                case (bus.cfg_sel)
                    2'd0:    s1_q <= bus.cfg_data;
                    2'd1:    s2_q <= bus.cfg_data;
                    2'd2:    s3_q <= bus.cfg_data;
                    default: ;
                endcase
            end
        end
    end

    // While en_taus is low the URNG reloads from s*_init. The one-cycle RESEED
    // dip is therefore what makes new seeds take effect.
    assign bus.en_taus  = (state_q == S_WARMUP) || (state_q == S_RUN);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.ready    = (state_q == S_RUN);
    assign bus.gnt      = gnt_q;
    assign bus.rnd_data = rnd_q;
    assign bus.s1_init  = s1_q;
    assign bus.s2_init  = s2_q;
    assign bus.s3_init  = s3_q;
endmodule

// File: tb/tb_taus_urng_ctrl.sv
// Self-checking bench for taus_urng_ctrl. It contains a stand-in Tausworthe
// URNG that reloads while en_taus is low. It also contains a stream-level model:
// the n-th word after a seed load, round-robin sharing of RUN cycles, and a
// warm-up of WARMUP discarded cycles. The model is compared against the DUT on
// every cycle. Directed literal checks pin latencies and the grant patterns.
module tb_taus_urng_ctrl;
    localparam int          NREQ = 4;
    localparam int          W    = 16;
    localparam logic [63:0] S1D  = 64'd11357407135578037661;
    localparam logic [63:0] S2D  = 64'd16405737874297512876;
    localparam logic [63:0] S3D  = 64'd13098074952039773637;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    taus_urng_ctrl_if #(.NREQ(NREQ)) bus();

    taus_urng_ctrl #(
        .NREQ(NREQ), .WARMUP(W), .S1_DEF(S1D), .S2_DEF(S2D), .S3_DEF(S3D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [191:0] taus_next(input logic [191:0] s);
        logic [63:0] a, b, c, t;
        a = s[191:128]; b = s[127:64]; c = s[63:0];
        t = ((a << 13) ^ a) >> 19; a = ((a & 64'hFFFF_FFFF_FFFF_FFFE) << 12) ^ t;
        t = ((b << 2)  ^ b) >> 25; b = ((b & 64'hFFFF_FFFF_FFFF_FFF8) << 4)  ^ t;
        t = ((c << 3)  ^ c) >> 11; c = ((c & 64'hFFFF_FFFF_FFFF_FFF0) << 17) ^ t;
        return {a, b, c};
    endfunction

    function automatic logic [63:0] taus_word(input logic [191:0] s);
        return s[191:128] ^ s[127:64] ^ s[63:0];
    endfunction

    // Stand-in URNG: it reloads while disabled and advances while enabled.
    logic [191:0] urng_q;
    always @(posedge clk) begin
        if (!bus.en_taus) urng_q <= {bus.s1_init, bus.s2_init, bus.s3_init};
        else              urng_q <= taus_next(urng_q);
    end
    assign bus.taus_out = taus_word(urng_q);

    function automatic bit seed_ok(input logic [1:0] sel, input logic [63:0] d);
`ifdef TAUS_SEED_CHECK_EN
        case (sel)
            2'd0:    return d >= 64'd2;
            2'd1:    return d >= 64'd8;
            default: return d >= 64'd16;
        endcase
`else
        return (sel != 2'd3) || (d == d);
`endif
    endfunction

    // ---------------- stream-level model ----------------
    logic [63:0]     m_seed [3];
    bit              m_en, m_rs;        // enabled (warm-up or run) / reseed dip
    int              m_cyc, m_ptr;      // enabled cycles since seed load
    logic [NREQ-1:0] e_gnt;
    logic [63:0]     e_rnd;
    bit              e_err;
    logic [63:0]     stream [512];      // word n after seed load
    logic [63:0]     rec_q [$];         // first 8 granted words of the first run

    task automatic load_stream(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic [191:0] s;
        s = {a, b, c};
        for (int i = 0; i < 512; i++) begin
            stream[i] = taus_word(s);
            s = taus_next(s);
        end
    endtask

    task automatic model_step();
        logic [63:0] ld [3];
        bit acc, vsel;
        int k;
        ld    = m_seed;
        vsel  = bus.cfg_wr && (bus.cfg_sel != 2'd3);
        acc   = vsel && seed_ok(bus.cfg_sel, bus.cfg_data);
        e_err = vsel && !seed_ok(bus.cfg_sel, bus.cfg_data);
        e_gnt = '0;
        if (m_en && m_cyc >= W && !bus.stop && !acc) begin
            k = -1;
            for (int i = 0; i < NREQ; i++)
                if (k < 0 && bus.req[(m_ptr + i) % NREQ]) k = (m_ptr + i) % NREQ;
            if (k >= 0) begin
                e_gnt = NREQ'(1) << k;
                e_rnd = (m_cyc < 512) ? stream[m_cyc] : 64'hx;
                m_ptr = (k + 1) % NREQ;
                if (rec_q.size() < 8) rec_q.push_back(e_rnd);
            end
        end
        if (acc) m_seed[bus.cfg_sel] = bus.cfg_data;
        if (bus.stop) begin
            m_en = 1'b0; m_rs = 1'b0;
        end else if (acc && m_en) begin
            m_en = 1'b0; m_rs = 1'b1;
        end else if (m_rs || (!m_en && bus.start)) begin
            m_rs = 1'b0; m_en = 1'b1; m_cyc = 0;
            load_stream(ld[0], ld[1], ld[2]);
        end else if (m_en && m_cyc < 100000) begin
            m_cyc++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_seed[0] = S1D; m_seed[1] = S2D; m_seed[2] = S3D;
                m_en = 1'b0; m_rs = 1'b0; m_cyc = 0; m_ptr = 0;
                e_gnt = '0; e_rnd = '0; e_err = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst) begin
                chk("m_gnt",     bus.gnt,      e_gnt);
                chk("m_rnd",     bus.rnd_data, e_rnd);
                chk("m_en_taus", bus.en_taus,  m_en);
                chk("m_busy",    bus.busy,     m_en || m_rs);
                chk("m_ready",   bus.ready,    m_en && m_cyc >= W);
                chk("m_cfg_err", bus.cfg_err,  e_err);
                chk("m_s1",      bus.s1_init,  m_seed[0]);
                chk("m_s2",      bus.s2_init,  m_seed[1]);
                chk("m_s3",      bus.s3_init,  m_seed[2]);
            end
        end
    end

    // n: negedges until gnt!=0, rn: negedge at which ready was first seen high.
    task automatic wait_gnt(output int n, output int rn);
        n = 0; rn = -1;
        while (bus.gnt == '0 && n < 100) begin
            if (rn < 0 && bus.ready) rn = n;
            @(negedge clk);
            n++;
        end
        if (rn < 0 && bus.ready) rn = n;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [63:0] d);
        bus.cfg_wr = 1'b1; bus.cfg_sel = sel; bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_wr = 1'b0;
    endtask

    logic [NREQ-1:0] rr_exp [5];

    initial begin
        int n, rn;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.start = 0; bus.stop = 0; bus.cfg_wr = 0; bus.cfg_sel = 0;
        bus.cfg_data = 0; bus.req = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rnd", bus.rnd_data, 0);
        chk("rst_en", bus.en_taus, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_s1", bus.s1_init, S1D);
        chk("rst_s3", bus.s3_init, S3D);
        rst = 1'b1; mon_en = 1'b1;
        @(negedge clk);

        // start, warm-up latency, full round-robin
        bus.start = 1'b1; bus.req = 4'b1111;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_en", bus.en_taus, 1);
        chk("start_busy", bus.busy, 1);
        chk("start_ready", bus.ready, 0);
        wait_gnt(n, rn);
        chk("first_gnt_lat", n, W + 1);
        chk("ready_lat", rn, W);
        for (int i = 0; i < 5; i++) begin
            chk("rr_1111", bus.gnt, rr_exp[i]);
            if (i < 4) @(negedge clk);
        end
        bus.req = 4'b0101;
        @(negedge clk); chk("rr_0101_a", bus.gnt, 4'b0100);
        @(negedge clk); chk("rr_0101_b", bus.gnt, 4'b0001);
        @(negedge clk); chk("rr_0101_c", bus.gnt, 4'b0100);
        bus.req = '0;
        repeat (3) begin
            @(negedge clk); chk("no_req_gnt", bus.gnt, 0);
        end

        // reserved select is ignored
        cfg_write(2'd3, 64'd0);
        chk("sel3_en", bus.en_taus, 1);
        chk("sel3_s1", bus.s1_init, S1D);

        // reseed s1=5 in RUN
        bus.req = 4'b1111;
        cfg_write(2'd0, 64'd5);
        chk("reseed_s1", bus.s1_init, 64'd5);
        chk("reseed_en_low", bus.en_taus, 0);
        chk("reseed_gnt", bus.gnt, 0);
        @(negedge clk);
        chk("reseed_en_back", bus.en_taus, 1);
        wait_gnt(n, rn);
        chk("reseed_gnt_lat", n, W + 1);
        repeat (4) @(negedge clk);

        // s3 below minimum
        cfg_write(2'd2, 64'd10);
`ifdef TAUS_SEED_CHECK_EN
        chk("bad_seed_err", bus.cfg_err, 1);
        chk("bad_seed_s3", bus.s3_init, S3D);
        chk("bad_seed_en", bus.en_taus, 1);
        @(negedge clk);
        chk("bad_seed_err_pulse", bus.cfg_err, 0);
`else
        chk("any_seed_s3", bus.s3_init, 64'd10);
        chk("any_seed_en", bus.en_taus, 0);
        chk("any_seed_err", bus.cfg_err, 0);
        @(negedge clk);
`endif
        repeat (3) @(negedge clk);

        // stop, restore seeds in IDLE, start again, replay
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_en", bus.en_taus, 0);
        chk("stop_busy", bus.busy, 0);
        chk("stop_ready", bus.ready, 0);
        chk("stop_gnt", bus.gnt, 0);
        cfg_write(2'd0, S1D);
        cfg_write(2'd2, S3D);
        chk("idle_wr_en", bus.en_taus, 0);
        chk("idle_wr_s1", bus.s1_init, S1D);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_gnt(n, rn);
        chk("restart_gnt_lat", n, W + 1);
        chk("rec_count", rec_q.size(), 8);
        for (int i = 0; i < rec_q.size(); i++) begin
            chk("replay_word", bus.rnd_data, rec_q[i]);
            @(negedge clk);
        end

        // reseed s2, then asynchronous reset mid-RUN
        cfg_write(2'd1, 64'h1234);
        chk("s2_written", bus.s2_init, 64'h1234);
        repeat (22) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_gnt", bus.gnt, 0);
        chk("arst_rnd", bus.rnd_data, 0);
        chk("arst_en", bus.en_taus, 0);
        chk("arst_ready", bus.ready, 0);
        chk("arst_s1", bus.s1_init, S1D);
        chk("arst_s2", bus.s2_init, S2D);
        chk("arst_s3", bus.s3_init, S3D);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/taus_urng_ctrl.md
# taus_urng_ctrl

Sequencing and sharing controller for the 64-bit Tausworthe URNG that feeds the ICDF Gaussian path. It owns the URNG seeds and enable. It discards the warm-up outputs after every (re)seed and shares the one-number-per-cycle stream among `NREQ` requesters with round-robin arbitration. It sits between the URNG instance and the ICDF lookup/requester logic.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `WARMUP`, default 16: enabled cycles discarded after each seed load before grants begin; minimum 3.
- `S1_DEF`, default 64'd11357407135578037661: s1 seed loaded at reset.
- `S2_DEF`, default 64'd16405737874297512876: s2 seed loaded at reset.
- `S3_DEF`, default 64'd13098074952039773637: s3 seed loaded at reset.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level/pulse; in IDLE, begins a run.
- `stop`  in  1  level/pulse; returns to IDLE from any state.
- `cfg_wr`  in  1  seed write strobe.
- `cfg_sel`  in  2  seed select: 0=s1, 1=s2, 2=s3; 3 is ignored.
- `cfg_data`  in  64  seed value.
- `cfg_err`  out  1  one-cycle pulse when a seed write is rejected.
- `busy`  out  1  high in WARMUP, RUN or RESEED.
- `ready`  out  1  high only in RUN.
- `req`  in  NREQ  per-requester request level.
- `gnt`  out  NREQ  one-hot, one-cycle grant.
- `rnd_data`  out  64  random word; valid in the cycle `gnt` is nonzero.
- `en_taus`  out  1  drives the URNG enable.
- `s1_init`, `s2_init`, `s3_init`  out  64 each  drive the URNG seeds.
- `taus_out`  in  64  URNG output.

## Operation
- States:
  - IDLE: `en_taus`=0.
  - WARMUP: `en_taus`=1; counts to `WARMUP`.
  - RUN: `en_taus`=1; arbitrating.
  - RESEED: `en_taus`=0 for exactly 1 cycle so the URNG reloads its `s*_init`.
- Transitions:
  - IDLE: `start` goes to WARMUP.
  - WARMUP: when the count reaches `WARMUP`-1, goes to RUN.
  - WARMUP or RUN: an accepted `cfg_wr` goes to RESEED.
  - RESEED always goes to WARMUP; the counter clears.
  - Any state: `stop` goes to IDLE.
- Priority when events coincide: `stop` > `cfg_wr` reseed > `start`/count.
  - `start` outside IDLE is ignored.
  - `cfg_wr` in IDLE updates the seed only; the state is unchanged.
  - `cfg_wr` together with `stop`: the seed is written and the next state is IDLE.
- Seed registers:
  - Reset to the `S*_DEF` parameters.
  - Written on an accepted `cfg_wr`.
  - Driven continuously on `s*_init`.
- The URNG restarts from its seeds whenever `en_taus` falls. Stop followed by start therefore replays an identical sequence.
- Arbitration happens in RUN only:
  - Each cycle, the lowest-index asserted `req` is chosen, starting from `ptr`.
  - Registered outputs: `gnt` gets that bit, `rnd_data` gets `taus_out`, and `ptr` becomes granted index+1 modulo `NREQ`.
  - `ptr` resets to 0.
  - With no `req` asserted, `gnt`=0 and the `taus_out` word is discarded. `rnd_data` holds its last value.
  - Each word is granted to at most one requester; words are never duplicated.
- Requester handshake:
  - Hold `req` until `gnt` is seen.
  - `req` may stay high to receive back-to-back grants, subject to round-robin.
- Outside RUN, `gnt`=0.
- Reset values: state IDLE; `gnt`=0, `rnd_data`=0, `en_taus`=0, `busy`=0, `ready`=0, `cfg_err`=0; `s*_init`=`S*_DEF`; `ptr`=0; counter 0.
- Reset mid-operation takes effect immediately, without a clock. Any grant in flight is lost.

## Timing
- `start` sampled at edge N: `en_taus` and `busy` rise after edge N.
- First possible grant appears after edge N+`WARMUP`+1. `ready` rises one edge earlier.
- `req` sampled at edge M in RUN: `gnt`/`rnd_data` valid after edge M (1-cycle registered latency).
- Accepted `cfg_wr` at edge K:
  - `en_taus` is low for the single cycle after edge K.
  - `gnt` is 0 from after edge K through the WARMUP period.
- `stop` at edge K: `en_taus`, `busy`, `ready` and `gnt` are all 0 after edge K.
- `cfg_err` is high for the single cycle after the rejecting edge.

## Configuration
- Macro: `TAUS_SEED_CHECK_EN`.
- Defined:
  - A write is rejected if s1 < 2, s2 < 8 or s3 < 16 (the Tausworthe minimums).
  - On rejection: seed unchanged, no RESEED, `cfg_err` pulses.
- Undefined:
  - All seed writes are accepted.
  - `cfg_err` is tied to 0.

## Test plan
- Reset, then `start` with defaults and `WARMUP`=16 -> `en_taus` high 1 cycle later; no `gnt` for 16 cycles. First `rnd_data` matches the model's taus_out stream.
- `req`=4'b1111 held in RUN -> `gnt` = 0001, 0010, 0100, 1000, 0001… every cycle. `rnd_data` equals consecutive model words.
- `req`=4'b0101 after a grant to requester 0 -> next grant 0100, then 0001. With `req`=0, the model advances but no `gnt`.
- `cfg_wr`, `cfg_sel`=0, `cfg_data`=5 in RUN:
  - `s1_init`=5; `en_taus` low exactly 1 cycle; 16 cycles with no `gnt`.
  - The stream then matches the model seeded with 5 and the defaults for s2/s3.
- With `TAUS_SEED_CHECK_EN`: `cfg_sel`=2, `cfg_data`=10 -> `cfg_err` 1-cycle pulse, `s3_init` unchanged, `en_taus` stays high. Without the macro: the write is accepted and a reseed occurs.
- `stop` then `start` replays the first 8 granted words identically. `rst` low mid-RUN between edges -> `gnt`, `rnd_data`, `en_taus` = 0 immediately and `s*_init` = defaults.
